// File: rtl/zjh_scan_rx.sv
// zjh_scan_rx: receives a multiplexed 4-digit 7-segment scan and recovers the digits
// Ports:
//   Clock      rising-edge system clock
//   Aclr       asynchronous active-low reset
//   Y[3:0]     active-low digit selects (async), Y[k] low selects digit k
//   seg[6:0]   active-high segments a..g on seg[6]..seg[0] (async)
//   rx_valid   one-cycle pulse when a digit is captured
//   rx_idx     captured digit index, valid with rx_valid
//   rx_bcd     captured digit value, valid with rx_valid
//   digits     held digit values, digits[4k+3:4k] = digit k
//   frame_done one-cycle pulse once all four digits were captured
//   err        sticky error flag
module zjh_scan_rx #(
  parameter int unsigned STABLE_CYC = 2
) (
  input  logic        Clock,
  input  logic        Aclr,
  input  logic [3:0]  Y,
  input  logic [6:0]  seg,
  output logic        rx_valid,
  output logic [1:0]  rx_idx,
  output logic [3:0]  rx_bcd,
  output logic [15:0] digits,
  output logic        frame_done,
  output logic        err
);
  localparam logic [3:0] STB = 4'(STABLE_CYC);
  typedef enum logic [1:0] {WAIT, COUNT, HELD} state_t;
  state_t      state_q, state_d;
  logic [3:0]  y_s1_q, y_q;
  logic [6:0]  seg_s1_q, seg_q;
  logic [10:0] ref_q, ref_d, samp;
  logic [3:0]  cnt_q, cnt_d, bad_q, bad_d, mask_q, mask_d, sel_n, bcd;
  logic [15:0] digits_d;
  logic [1:0]  idx;
  logic        valid, multi, load, cap, err_d;

  function automatic logic [3:0] decode(input logic [6:0] s);
    case (s)
      7'b1111110: decode = 4'd0;
      7'b0110000: decode = 4'd1;
      7'b1101101: decode = 4'd2;
      7'b1111001: decode = 4'd3;
      7'b0110011: decode = 4'd4;
      7'b1011011: decode = 4'd5;
      7'b0011111,
      7'b1011111: decode = 4'd6;
      7'b1110000: decode = 4'd7;
      7'b1111111: decode = 4'd8;
      7'b1110011,
      7'b1111011: decode = 4'd9;
      7'b0000000: decode = 4'hF;
      default:    decode = 4'hE;
    endcase
  endfunction

  always_comb begin
    sel_n = ~y_q;
    // exactly one select low: non-zero and a power of two
    valid = (sel_n != 4'h0) && ((sel_n & (sel_n - 4'h1)) == 4'h0);
    multi = (sel_n != 4'h0) && !valid;
    samp  = {y_q, seg_q};
    idx   = !y_q[0] ? 2'd0 : !y_q[1] ? 2'd1 : !y_q[2] ? 2'd2 : 2'd3;
    bcd   = decode(seg_q);
    state_d = state_q;
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    load    = 1'b0;
    case (state_q)
      WAIT: load = valid;
      COUNT:
        if (samp == ref_q) begin
          cnt_d   = (cnt_q == STB) ? cnt_q : cnt_q + 4'd1;
          cap     = (cnt_q == STB - 4'd1);
          state_d = cap ? HELD : COUNT;
        end else if (valid) begin
          load = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = 4'd0;
        end
      HELD:
        // only a select change leaves HELD; segment changes are ignored
        if (y_q != ref_q[10:7]) begin
          load    = valid;
          state_d = valid ? HELD : WAIT;
          cnt_d   = valid ? cnt_q : 4'd0;
        end
      default: state_d = WAIT;
    endcase
    // a fresh valid pair restarts the window; with a 1-cycle window it captures at once
    if (load) begin
      ref_d   = samp;
      cnt_d   = 4'd1;
      cap     = (STB == 4'd1);
      state_d = cap ? HELD : COUNT;
    end
    bad_d    = multi ? ((bad_q == STB) ? bad_q : bad_q + 4'd1) : 4'd0;
    err_d    = err | (multi && (bad_q >= STB - 4'd1)) | (cap && (bcd == 4'hE));
    // a full mask is cleared on the cycle frame_done is raised; a capture then lands in the cleared mask
    mask_d   = ((mask_q == 4'hF) ? 4'h0 : mask_q) | (cap ? (4'b0001 << idx) : 4'h0);
    digits_d = cap ? ((digits & ~(16'hF << {idx, 2'b00})) | (16'(bcd) << {idx, 2'b00})) : digits;
  end

  always_ff @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      y_s1_q     <= 4'hF;
      y_q        <= 4'hF;
      seg_s1_q   <= 7'h0;
      seg_q      <= 7'h0;
      state_q    <= WAIT;
      ref_q      <= {4'hF, 7'h0};
      cnt_q      <= 4'd0;
      bad_q      <= 4'd0;
      mask_q     <= 4'h0;
      digits     <= 16'hFFFF;
      rx_valid   <= 1'b0;
      rx_idx     <= 2'd0;
      rx_bcd     <= 4'd0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      y_s1_q     <= Y;
      y_q        <= y_s1_q;
      seg_s1_q   <= seg;
      seg_q      <= seg_s1_q;
      state_q    <= state_d;
      ref_q      <= ref_d;
      cnt_q      <= cnt_d;
      bad_q      <= bad_d;
      mask_q     <= mask_d;
      digits     <= digits_d;
      rx_valid   <= cap;
      rx_idx     <= cap ? idx : rx_idx;
      rx_bcd     <= cap ? bcd : rx_bcd;
      frame_done <= (mask_q == 4'hF);
      err        <= err_d;
    end
  end
endmodule

// File: doc/zjh_scan_rx.md
ZJH_SCAN_RX -- requirements
Module: zjh_scan_rx

Interface
REQ-001 Parameter STABLE_CYC, default 2, meaning: consecutive identical synchronized samples required before a digit is captured (legal range 1..15).
REQ-002 Clock  input  1  rising-edge system clock; only clock in the block.
REQ-003 Aclr  input  1  asynchronous, active-low reset.
REQ-004 Y  input  4  digit selects, active-low, Y[0]=digit 0 .. Y[3]=digit 3, asynchronous to Clock.
REQ-005 seg  input  7  segment lines, active-high, seg[6]=a .. seg[0]=g, asynchronous to Clock.
REQ-006 rx_valid  output  1  one-cycle pulse: new digit captured.
REQ-007 rx_idx  output  2  index of captured digit, valid with rx_valid.
REQ-008 rx_bcd  output  4  decoded value of captured digit, valid with rx_valid.
REQ-009 digits  output  16  held digit registers, digits[4k+3:4k]=digit k.
REQ-010 frame_done  output  1  one-cycle pulse: all four digits captured since last pulse.
REQ-011 err  output  1  sticky error flag; cleared only by reset.

Function
REQ-012 Y and seg SHALL pass through a 2-flop synchronizer; all logic below uses synchronized values only.
REQ-013 Segment decode SHALL be: 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 0011111 or 1011111->6, 1110000->7, 1111111->8, 1110011 or 1111011->9, 0000000->4'hF (blank).
REQ-014 Any other seg pattern SHALL decode to 4'hE and set err when captured.
REQ-015 A select sample is "valid" when exactly one bit of synchronized Y is 0.
REQ-016 Capture FSM states: WAIT, COUNT, HELD.
REQ-017 WAIT: on a valid select, load reference {Y,seg}, counter=1, go COUNT (or capture immediately if STABLE_CYC=1).
REQ-018 COUNT: if sample equals reference, increment counter; on reaching STABLE_CYC, capture and go HELD.
REQ-019 COUNT: if sample differs but is valid, reload reference, counter=1, stay COUNT; if not valid, go WAIT.
REQ-020 HELD: stay while Y is unchanged (seg changes ignored); Y change to a valid select -> reload, COUNT; Y change to invalid -> WAIT.
REQ-021 Capture SHALL, in the same cycle, write digits[idx], assert rx_valid with rx_idx/rx_bcd, and set captured-mask bit idx.
REQ-022 Capture latency: rx_valid asserts exactly 2 (sync) + STABLE_CYC cycles after a stable select/seg pair appears at the inputs.
REQ-023 When the captured mask becomes 4'b1111, frame_done SHALL pulse the following cycle and the mask SHALL clear in that cycle; a capture in that same cycle sets its bit in the cleared mask.
REQ-024 Recapturing an already-captured digit before frame completion SHALL update digits but not alter the mask.
REQ-025 More than one Y bit low for STABLE_CYC consecutive cycles SHALL set err; all Y high is a legal blanking gap and SHALL NOT set err.
REQ-026 Counter SHALL saturate at STABLE_CYC; no wrap-around.

Reset
REQ-027 Aclr low SHALL immediately force: FSM=WAIT, counter=0, synchronizers=1 for Y and 0 for seg, digits=16'hFFFF, mask=0, rx_valid=0, rx_idx=0, rx_bcd=0, frame_done=0, err=0.
REQ-028 Aclr deasserted mid-capture SHALL restart detection from WAIT; no partial capture is reported.

Verification
REQ-029 Y=1110, seg=1101101 held 6 cycles, STABLE_CYC=2 -> single rx_valid 4 cycles after apply, rx_idx=0, rx_bcd=2, digits[3:0]=2.
REQ-030 Scan Y=1110/1101/1011/0111 with 7,3,8,0, 8 cycles each -> four rx_valid pulses, digits=16'h0837, one frame_done after the fourth capture.
REQ-031 Y=1011 with seg toggling each cycle between two patterns -> no rx_valid, err stays 0.
REQ-032 Y=1100 held 5 cycles -> err=1, no rx_valid; then Y=1110, seg=0011111 -> rx_bcd=6, err stays 1.
REQ-033 seg=1000001 on digit 1 -> rx_bcd=4'hE, err=1; seg=0000000 on digit 2 -> rx_bcd=4'hF, err unchanged.
REQ-034 Aclr pulsed low during COUNT on digit 3 -> all outputs return to reset values immediately; no rx_valid until a fresh stable window completes.
